// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencer for the multicycle RV32I datapath
//
// Purpose:
//   Steps each instruction through fetch, decode, execute, memory and
//   writeback over one shared ALU and one unified memory. Branches are
//   resolved from the ALU flags. Memory steps stall on mem_ready.
//
// Optional feature:
//   MC_ILLEGAL_TRAP_EN
//     When defined, unknown opcodes and unsupported funct3/funct7
//     combinations enter TRAP and set the sticky illegal flag.
//     When undefined, unknown opcodes retire as NOPs and illegal is tied 0.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   nzcv                  ALU flags {N,Z,C,V} for this cycle's ALU op
//   opcode/funct3/funct7  instruction fields from the instruction register
//   mem_ready             memory access completes this cycle
//   PCWrite, IRWrite,     register enables
//   RegWrite, MemWrite
//   AdrSrc                memory address select: 0=PC, 1=Result
//   ResultSrc             00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA               00=PC, 01=OldPC, 10=rs1
//   ALUSrcB               00=rs2, 01=ImmExt, 10=constant 4
//   ImmSrc                00=I, 01=S, 10=B, 11=J
//   ALUControl            ALU operation code
//   state                 current state, for debug
//   illegal               sticky illegal-instruction flag
module multicycle_controller #(
  parameter int STATE_W       = 4,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         nzcv,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [4:0]         ALUControl,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] ST_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] ST_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] ST_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] ST_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] ST_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] ST_JAL      = STATE_W'(10);
  localparam logic [STATE_W-1:0] ST_TRAP     = STATE_W'(11);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] out_state;
  logic               ready;
  logic               flag_n, flag_z, flag_c, flag_v;
  logic               btaken;
  logic               pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  assign ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

  // While reset is held the outputs decode as FETCH; the write enables are
  // masked separately below.
  assign out_state = reset ? ST_FETCH : state_q;

  function automatic logic [4:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7,
                                            input logic       is_r);
    logic [4:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = f7 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Branch condition from the flags of rs1 - rs2.
  always_comb begin
    btaken = 1'b0;
    case (funct3)
      3'b000: btaken = flag_z;
      3'b001: btaken = !flag_z;
      3'b100: btaken = flag_n ^ flag_v;
      3'b101: btaken = !(flag_n ^ flag_v);
      3'b110: btaken = !flag_c;
      3'b111: btaken = flag_c;
      default: btaken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  // Output decode
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    case (out_state)
      ST_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = ready;
        pc_write_raw = ready;
      end
      ST_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      ST_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      ST_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      ST_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      ST_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      ST_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct7, 1'b1);
      end
      ST_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, funct7, 1'b0);
      end
      ST_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUControl   = ALU_SUB;
        pc_write_raw = btaken;
      end
      ST_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PCWrite  = pc_write_raw  & !reset;
  assign IRWrite  = ir_write_raw  & !reset;
  assign MemWrite = mem_write_raw & !reset;
  assign RegWrite = reg_write_raw & !reset;

  // Next-state logic
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECUTER;
          OP_ITYPE:          state_d = ST_EXECUTEI;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           state_d = ST_TRAP;
`else
          default:           state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  state_d = ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: state_d = ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECUTER: begin
`ifdef MC_ILLEGAL_TRAP_EN
        // funct7=1 is only meaningful for sub (000) and sra (101).
        if (funct7 && (funct3 != 3'b000) && (funct3 != 3'b101))
          state_d = ST_TRAP;
        else
          state_d = ST_ALUWB;
`else
        state_d = ST_ALUWB;
`endif
      end
      ST_EXECUTEI: state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH: begin
`ifdef MC_ILLEGAL_TRAP_EN
        if ((funct3 == 3'b010) || (funct3 == 3'b011))
          state_d = ST_TRAP;
        else
          state_d = ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_JAL: state_d = ST_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset)                  illegal_q <= 1'b0;
    else if (state_d == ST_TRAP) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] nzcv;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [4:0] ALUControl;
  logic [3:0] state;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .nzcv      (nzcv),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .ALUControl(ALUControl),
    .state     (state),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; nzcv = 4'b0000; opcode = 7'b0110011;
    funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
    tick(); tick();

    // Reset: FETCH decode with enables masked
    check("rst_state", 32'(state), 0);
    check("rst_pcwrite", 32'(PCWrite), 0);
    check("rst_irwrite", 32'(IRWrite), 0);
    check("rst_resultsrc", 32'(ResultSrc), 2);
    check("rst_alusrcb", 32'(ALUSrcB), 2);
    check("rst_illegal", 32'(illegal), 0);

    reset = 1'b0; #1;
    check("fetch_pcwrite", 32'(PCWrite), 1);
    check("fetch_irwrite", 32'(IRWrite), 1);
    // FETCH stall
    mem_ready = 1'b0; #1;
    check("fetch_stall_irwrite", 32'(IRWrite), 0);
    tick();
    check("fetch_stall_state", 32'(state), 0);
    mem_ready = 1'b1;

    // add: 0,1,6,8,0
    tick();
    check("add_s1", 32'(state), 1);
    check("add_dec_srca", 32'(ALUSrcA), 1);
    check("add_dec_srcb", 32'(ALUSrcB), 1);
    tick();
    check("add_s6", 32'(state), 6);
    check("add_aluctl", 32'(ALUControl), 5'b00000);
    check("add_exe_regwrite", 32'(RegWrite), 0);
    check("add_exe_srca", 32'(ALUSrcA), 2);
    funct7 = 1'b1; #1;
    check("sub_aluctl", 32'(ALUControl), 5'b00001);
    funct3 = 3'b101; #1;
    check("sra_r_aluctl", 32'(ALUControl), 5'b01001);
    funct3 = 3'b000;
    tick();
    check("add_s8", 32'(state), 8);
    check("add_wb_regwrite", 32'(RegWrite), 1);
    check("add_wb_resultsrc", 32'(ResultSrc), 0);
    funct7 = 1'b0;
    tick();
    check("add_s0", 32'(state), 0);

    // addi with funct7 high stays ADD; srai decodes SRA
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 1'b1;
    tick(); tick();
    check("addi_s7", 32'(state), 7);
    check("addi_aluctl", 32'(ALUControl), 5'b00000);
    check("addi_srcb", 32'(ALUSrcB), 1);
    funct3 = 3'b101; #1;
    check("srai_aluctl", 32'(ALUControl), 5'b01001);
    funct3 = 3'b111; funct7 = 1'b0; #1;
    check("andi_aluctl", 32'(ALUControl), 5'b00010);
    tick(); tick();
    check("addi_done", 32'(state), 0);

    // lw with two stall cycles: 0,1,2,3,3,3,4,0
    opcode = 7'b0000011; funct3 = 3'b010; #1;
    check("lw_immsrc", 32'(ImmSrc), 0);
    tick();
    check("lw_s1", 32'(state), 1);
    tick();
    check("lw_s2", 32'(state), 2);
    check("lw_memadr_srca", 32'(ALUSrcA), 2);
    tick();
    mem_ready = 1'b0; #1;
    check("lw_s3a", 32'(state), 3);
    check("lw_adrsrc", 32'(AdrSrc), 1);
    tick();
    check("lw_s3b", 32'(state), 3);
    tick();
    check("lw_s3c", 32'(state), 3);
    mem_ready = 1'b1;
    tick();
    check("lw_s4", 32'(state), 4);
    check("lw_regwrite", 32'(RegWrite), 1);
    check("lw_resultsrc", 32'(ResultSrc), 1);
    tick();
    check("lw_s0", 32'(state), 0);

    // Branches
    opcode = 7'b1100011; funct3 = 3'b000; nzcv = 4'b0100; #1;
    check("br_immsrc", 32'(ImmSrc), 2);
    tick(); tick();
    check("br_s9", 32'(state), 9);
    check("beq_pcwrite", 32'(PCWrite), 1);
    check("br_aluctl", 32'(ALUControl), 5'b00001);
    funct3 = 3'b001; #1;
    check("bne_pcwrite", 32'(PCWrite), 0);
    funct3 = 3'b110; nzcv = 4'b0000; #1;
    check("bltu_pcwrite", 32'(PCWrite), 1);
    funct3 = 3'b101; nzcv = 4'b1000; #1;
    check("bge_pcwrite", 32'(PCWrite), 0);
    funct3 = 3'b100; #1;
    check("blt_pcwrite", 32'(PCWrite), 1);
    funct3 = 3'b111; nzcv = 4'b0010; #1;
    check("bgeu_pcwrite", 32'(PCWrite), 1);
    tick();
    check("br_s0", 32'(state), 0);
    nzcv = 4'b0000;

    // jal: 0,1,10,8,0
    opcode = 7'b1101111; #1;
    check("jal_immsrc", 32'(ImmSrc), 3);
    tick();
    check("jal_s1", 32'(state), 1);
    tick();
    check("jal_s10", 32'(state), 10);
    check("jal_pcwrite", 32'(PCWrite), 1);
    check("jal_srca", 32'(ALUSrcA), 1);
    check("jal_srcb", 32'(ALUSrcB), 2);
    tick();
    check("jal_s8", 32'(state), 8);
    tick();
    check("jal_s0", 32'(state), 0);

    // sw interrupted by reset in MEMWRITE
    opcode = 7'b0100011; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("sw_s5", 32'(state), 5);
    check("sw_memwrite", 32'(MemWrite), 1);
    tick();
    check("sw_hold_memwrite", 32'(MemWrite), 1);
    reset = 1'b1; #1;
    check("sw_rst_memwrite", 32'(MemWrite), 0);
    check("sw_rst_regwrite", 32'(RegWrite), 0);
    check("sw_rst_pcwrite", 32'(PCWrite), 0);
    tick();
    check("sw_rst_state", 32'(state), 0);
    reset = 1'b0; mem_ready = 1'b1; #1;
    check("sw_after_pcwrite", 32'(PCWrite), 1);

    // Unknown opcode
    opcode = 7'b0000000;
    tick();
    check("ill_s1", 32'(state), 1);
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    check("ill_trap_state", 32'(state), 11);
    check("ill_flag", 32'(illegal), 1);
    check("ill_trap_pcwrite", 32'(PCWrite), 0);
    tick();
    check("ill_trap_hold", 32'(state), 11);
    check("ill_flag_hold", 32'(illegal), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("ill_clear_state", 32'(state), 0);
    check("ill_clear_flag", 32'(illegal), 0);
`else
    check("ill_nop_state", 32'(state), 0);
    check("ill_flag_zero", 32'(illegal), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
